pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a filtered lock, retries
// on timeout and falls back to bypass once the retry budget is spent.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 48,
    parameter int LOCK_TIMEOUT_CYCLES = 48000,
    parameter int LOCK_STABLE_CYCLES  = 4800,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst_n,
    output logic       pll_bypass,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_lost_count
);

    localparam int MAX_A      = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock_s high is the first stable cycle,
    // so LOCK_FILTER only has to cover the remaining LOCK_STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYCLES > 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        LOCK_FILTER,
        RUN,
        FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sync_reg;
    logic             lock_s;
    logic             pll_rst_n_next, pll_bypass_next, ready_next, fault_next;
    logic [1:0]       retry_next;
    logic [7:0]       lost_next;

    assign lock_s = sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= PLL_RST;
            cnt_reg         <= '0;
            pll_rst_n       <= 1'b0;
            pll_bypass      <= 1'b0;
            ready           <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= 2'd0;
            lock_lost_count <= 8'd0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            pll_rst_n       <= pll_rst_n_next;
            pll_bypass      <= pll_bypass_next;
            ready           <= ready_next;
            fault           <= fault_next;
            retry_count     <= retry_next;
            lock_lost_count <= lost_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_count;
        lost_next  = lock_lost_count;

        case (state_reg)
            PLL_RST: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = LOCK_FILTER;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_LIMIT) begin
                        state_next = FAULT;
                    end else begin
                        retry_next = retry_count + 2'd1;
                        state_next = PLL_RST;
                    end
                end
            end
            LOCK_FILTER: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_reg >= STABLE_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = PLL_RST;
                    retry_next = 2'd0;
                    if (lock_lost_count != 8'hFF) begin
                        lost_next = lock_lost_count + 8'd1;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = PLL_RST;
            end
        endcase

        // Restart overrides everything, including a lock loss seen this cycle.
        if (restart) begin
            state_next = PLL_RST;
            retry_next = 2'd0;
            lost_next  = lock_lost_count;
        end

        if (restart || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if ((state_reg == RUN) || (state_reg == FAULT)) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        pll_rst_n_next  = (state_next == WAIT_LOCK) || (state_next == LOCK_FILTER) ||
                          (state_next == RUN);
        pll_bypass_next = (state_next == FAULT);
        fault_next      = (state_next == FAULT);
        ready_next      = (state_next == RUN);
    end

endmodule
